// File: rtl/seq_divider.sv
// Radix-2 restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor in WIDTH iterations,
// start/busy handshake shared with the Booth multiplier. Define DIVIDER_SIGNED_EN for two's complement.
module seq_divider #(
   parameter int WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [2*WIDTH-1:0]   i_x,
   input  logic [WIDTH-1:0]     i_y,
   input  logic                 i_start,
   output logic [WIDTH-1:0]     o_q,
   output logic [WIDTH-1:0]     o_r,
   output logic                 o_busy,
   output logic                 o_done,
   output logic                 o_dbz,
   output logic                 o_ovf
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH);
   localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0]    CNT_ZERO = {CW{1'b0}};
   localparam logic [WIDTH-1:0] Q_ZERO   = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] Q_ONES   = {WIDTH{1'b1}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [CW-1:0]        r_cnt;
   logic [WIDTH:0]       r_p;
   logic [WIDTH-1:0]     r_lo;
   logic [WIDTH:0]       r_ymag;
   logic [WIDTH-1:0]     r_q;
   logic [WIDTH-1:0]     r_r;
   logic                 r_busy;
   logic                 r_done;
   logic                 r_dbz;
   logic                 r_ovf;

   logic [2*WIDTH-1:0]   w_xmag;
   logic [WIDTH:0]       w_ymag;
   logic                 w_y_zero;
   logic                 w_pre_ovf;
   logic [WIDTH+1:0]     w_trial;
   logic                 w_trial_neg;
   logic [WIDTH-1:0]     w_q_fin;
   logic [WIDTH-1:0]     w_r_fin;
   logic                 w_ovf_fin;

`ifdef DIVIDER_SIGNED_EN
   localparam logic [2*WIDTH-1:0] X_ZERO    = {(2*WIDTH){1'b0}};
   localparam logic [WIDTH:0]     Y_ZERO    = {(WIDTH+1){1'b0}};
   localparam logic [WIDTH-1:0]   Q_MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0]   Q_MIN_MAG = {1'b1, {(WIDTH-1){1'b0}}};

   logic            r_xneg;
   logic            r_yneg;
   logic [WIDTH:0]  w_ysext;
   logic            w_qneg;

   // |y| is formed at WIDTH+1 bits so the most negative divisor keeps its magnitude
   assign w_xmag  = i_x[2*WIDTH-1] ? (X_ZERO - i_x) : i_x;
   assign w_ysext = {i_y[WIDTH-1], i_y};
   assign w_ymag  = i_y[WIDTH-1] ? (Y_ZERO - w_ysext) : w_ysext;
   assign w_qneg  = r_xneg ^ r_yneg;

   // Sign correction and signed range check of the magnitude quotient
   always_comb begin
      w_q_fin   = r_lo;
      w_r_fin   = r_p[WIDTH-1:0];
      w_ovf_fin = 1'b0;
      if (w_qneg) begin
         w_q_fin   = Q_ZERO - r_lo;
         w_ovf_fin = (r_lo > Q_MIN_MAG);
      end else begin
         w_q_fin   = r_lo;
         w_ovf_fin = (r_lo > Q_MAX_POS);
      end
      if (r_xneg) begin
         w_r_fin = Q_ZERO - r_p[WIDTH-1:0];
      end else begin
         w_r_fin = r_p[WIDTH-1:0];
      end
      if (w_ovf_fin) begin
         w_q_fin = Q_ONES;
         w_r_fin = Q_ZERO;
      end else begin
         w_q_fin = w_q_fin;
         w_r_fin = w_r_fin;
      end
   end

   // Operand signs captured with the accepted start
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_xneg <= 1'b0;
         r_yneg <= 1'b0;
      end else if ((r_state == S_IDLE) && i_start) begin
         r_xneg <= i_x[2*WIDTH-1];
         r_yneg <= i_y[WIDTH-1];
      end
   end
`else
   assign w_xmag = i_x;
   assign w_ymag = {1'b0, i_y};

   // Unsigned results come straight from the iteration registers
   always_comb begin
      w_q_fin   = r_lo;
      w_r_fin   = r_p[WIDTH-1:0];
      w_ovf_fin = 1'b0;
   end
`endif

   assign w_y_zero    = (i_y == Q_ZERO);
   assign w_pre_ovf   = ({1'b0, w_xmag[2*WIDTH-1:WIDTH]} >= w_ymag);
   assign w_trial     = {r_p, r_lo[WIDTH-1]} - {1'b0, r_ymag};
   assign w_trial_neg = w_trial[WIDTH+1];

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; CALC holds one extra cycle after the last bit for sign fix-up
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               if (w_y_zero || w_pre_ovf) begin
                  w_state_nxt = S_DONE;
               end else begin
                  w_state_nxt = S_CALC;
               end
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_CALC: begin
            if (r_cnt == CNT_LAST) begin
               w_state_nxt = S_DONE;
            end else begin
               w_state_nxt = S_CALC;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Datapath: operand latch, one restoring step per CALC cycle, result capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt  <= CNT_ZERO;
         r_p    <= {(WIDTH+1){1'b0}};
         r_lo   <= Q_ZERO;
         r_ymag <= {(WIDTH+1){1'b0}};
         r_q    <= Q_ZERO;
         r_r    <= Q_ZERO;
         r_dbz  <= 1'b0;
         r_ovf  <= 1'b0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_cnt  <= CNT_ZERO;
                  r_p    <= {1'b0, w_xmag[2*WIDTH-1:WIDTH]};
                  r_lo   <= w_xmag[WIDTH-1:0];
                  r_ymag <= w_ymag;
                  r_dbz  <= 1'b0;
                  r_ovf  <= 1'b0;
                  if (w_y_zero) begin
                     r_dbz <= 1'b1;
                     r_q   <= Q_ONES;
                     r_r   <= i_x[WIDTH-1:0];
                  end else if (w_pre_ovf) begin
                     r_ovf <= 1'b1;
                     r_q   <= Q_ONES;
                     r_r   <= Q_ZERO;
                  end
               end
            end
            S_CALC: begin
               if (r_cnt == CNT_LAST) begin
                  r_q   <= w_q_fin;
                  r_r   <= w_r_fin;
                  r_ovf <= w_ovf_fin;
               end else begin
                  r_p   <= w_trial_neg ? {r_p[WIDTH-1:0], r_lo[WIDTH-1]} : w_trial[WIDTH:0];
                  r_lo  <= {r_lo[WIDTH-2:0], ~w_trial_neg};
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end
            default: begin
               r_cnt <= r_cnt;
            end
         endcase
         r_busy <= (w_state_nxt == S_DONE) || (r_state == S_CALC);
         r_done <= (w_state_nxt == S_DONE);
      end
   end

   assign o_q    = r_q;
   assign o_r    = r_r;
   assign o_busy = r_busy;
   assign o_done = r_done;
   assign o_dbz  = r_dbz;
   assign o_ovf  = r_ovf;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: fixed vector table, corner sequences and
// randomized operations checked against an arithmetic reference model.
module tb_seq_divider;
   localparam int W = 16;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [2*W-1:0]   i_x;
   logic [W-1:0]     i_y;
   logic             i_start;
   logic [W-1:0]     o_q;
   logic [W-1:0]     o_r;
   logic             o_busy;
   logic             o_done;
   logic             o_dbz;
   logic             o_ovf;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   seq_divider #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .i_x(i_x), .i_y(i_y), .i_start(i_start),
      .o_q(o_q), .o_r(o_r), .o_busy(o_busy), .o_done(o_done),
      .o_dbz(o_dbz), .o_ovf(o_ovf)
   );

   typedef struct {
      logic [2*W-1:0] x;
      logic [W-1:0]   y;
      logic [W-1:0]   q;
      logic [W-1:0]   r;
      logic           dbz;
      logic           ovf;
      int             lat;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Reference: truncating division on integers, with the documented error conventions
   function automatic void model(input logic [2*W-1:0] x, input logic [W-1:0] y,
                                 output logic [W-1:0] q, output logic [W-1:0] r,
                                 output logic dbz, output logic ovf, output int lat);
      longint xs, ys, ax, ay, qt, rt;
`ifdef DIVIDER_SIGNED_EN
      xs = longint'($signed(x));
      ys = longint'($signed(y));
`else
      xs = longint'(x);
      ys = longint'(y);
`endif
      ax  = (xs < 64'sd0) ? -xs : xs;
      ay  = (ys < 64'sd0) ? -ys : ys;
      dbz = 1'b0;
      ovf = 1'b0;
      lat = W + 1;
      q   = '0;
      r   = '0;
      if (ys == 64'sd0) begin
         dbz = 1'b1; q = '1; r = x[W-1:0]; lat = 0;
      end else if ((ax >> W) >= ay) begin
         ovf = 1'b1; q = '1; r = '0; lat = 0;
      end else begin
         qt = xs / ys;
         rt = xs % ys;
         q  = qt[W-1:0];
         r  = rt[W-1:0];
`ifdef DIVIDER_SIGNED_EN
         if (qt > ((64'sd1 <<< (W - 1)) - 64'sd1) || qt < -(64'sd1 <<< (W - 1))) begin
            ovf = 1'b1; q = '1; r = '0;
         end
`endif
      end
   endfunction

   task automatic do_div(input logic [2*W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic edbz, input logic eovf, input int elat,
                         input string tag, input int poke);
      int lat;
      int busy_cnt;
      @(negedge clk);
      chk({tag, ".idle_done"}, 64'(o_done), 64'd0);
      chk({tag, ".idle_busy"}, 64'(o_busy), 64'd0);
      i_x = x; i_y = y; i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      i_x = $urandom;
      i_y = 16'($urandom);
      lat = 0;
      busy_cnt = 0;
      if (elat != 0) chk({tag, ".flags_clr"}, 64'({o_dbz, o_ovf}), 64'd0);
      while (!o_done && lat < 40) begin
         if (o_busy) busy_cnt++;
         if (poke > 0 && lat == poke) begin
            i_start = 1'b1; i_x = $urandom; i_y = 16'($urandom) | 16'd1;
         end
         if (poke > 0 && lat == poke + 3) i_start = 1'b0;
         @(negedge clk);
         lat++;
      end
      if (o_busy) busy_cnt++;
      chk({tag, ".latency"}, 64'(lat), 64'(elat));
      chk({tag, ".q"}, 64'(o_q), 64'(eq));
      chk({tag, ".r"}, 64'(o_r), 64'(er));
      chk({tag, ".dbz"}, 64'(o_dbz), 64'(edbz));
      chk({tag, ".ovf"}, 64'(o_ovf), 64'(eovf));
      chk({tag, ".busy_cycles"}, 64'(busy_cnt), (elat == 0) ? 64'd1 : 64'(W + 1));
   endtask

   vec_t           tbl[$];
   logic [2*W-1:0] rx;
   logic [W-1:0]   ry;
   logic [W-1:0]   mq, mr;
   logic           mdbz, movf;
   int             mlat;

   initial begin
      rst_n = 1'b0; i_start = 1'b0; i_x = '0; i_y = '0;
      repeat (2) @(negedge clk);
      chk("reset", 64'({o_q, o_r, o_busy, o_done, o_dbz, o_ovf}), 64'd0);
      rst_n = 1'b1;

`ifdef DIVIDER_SIGNED_EN
      tbl.push_back('{32'hFFFF_FC18, 16'd7,    16'hFF72, 16'hFFFA, 1'b0, 1'b0, 17});
      tbl.push_back('{32'hFFFF_FC18, 16'hFFF9, 16'h008E, 16'hFFFA, 1'b0, 1'b0, 17});
      tbl.push_back('{32'hFFFF_8000, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 17});
      tbl.push_back('{32'hFFFF_8000, 16'd1,    16'h8000, 16'h0000, 1'b0, 1'b0, 17});
      tbl.push_back('{32'h0000_7FFF, 16'd1,    16'h7FFF, 16'h0000, 1'b0, 1'b0, 17});
      tbl.push_back('{32'h0001_2345, 16'd0,    16'hFFFF, 16'h2345, 1'b1, 1'b0, 0});
      tbl.push_back('{32'h0001_0000, 16'd1,    16'hFFFF, 16'h0000, 1'b0, 1'b1, 0});
`else
      tbl.push_back('{32'd1000,      16'd7,    16'h008E, 16'd6,    1'b0, 1'b0, 17});
      tbl.push_back('{32'h0001_2345, 16'd0,    16'hFFFF, 16'h2345, 1'b1, 1'b0, 0});
      tbl.push_back('{32'h0001_0000, 16'd1,    16'hFFFF, 16'h0000, 1'b0, 1'b1, 0});
      tbl.push_back('{32'h0000_FFFF, 16'd1,    16'hFFFF, 16'h0000, 1'b0, 1'b0, 17});
      tbl.push_back('{32'hFFFE_FFFF, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0, 1'b0, 17});
      tbl.push_back('{32'd0,         16'd5,    16'h0000, 16'h0000, 1'b0, 1'b0, 17});
      tbl.push_back('{32'h0005_0000, 16'd5,    16'hFFFF, 16'h0000, 1'b0, 1'b1, 0});
`endif
      foreach (tbl[i])
         do_div(tbl[i].x, tbl[i].y, tbl[i].q, tbl[i].r, tbl[i].dbz, tbl[i].ovf,
                tbl[i].lat, $sformatf("vec%0d", i), 0);

      // start requests while busy must be dropped
      model(32'd1000, 16'd7, mq, mr, mdbz, movf, mlat);
      do_div(32'd1000, 16'd7, mq, mr, mdbz, movf, mlat, "busy_start", 4);

      // asynchronous reset in the middle of the iterations
      @(negedge clk);
      i_x = 32'd1000; i_y = 16'd7; i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      repeat (8) @(negedge clk);
      #1 rst_n = 1'b0;
      #1 chk("rst_mid", 64'({o_q, o_r, o_busy, o_done, o_dbz, o_ovf}), 64'd0);
      #1 rst_n = 1'b1;
      model(32'd1000, 16'd7, mq, mr, mdbz, movf, mlat);
      do_div(32'd1000, 16'd7, mq, mr, mdbz, movf, mlat, "after_rst", 0);

      for (int i = 0; i < 120; i++) begin
         rx = $urandom;
         ry = 16'($urandom);
         case (i % 4)
            0: rx = rx;
            1: rx[2*W-1:W] = '0;
            2: if (i % 8 == 2) ry = '0; else ry = ry | 16'd1;
            default: rx[2*W-1:W] = ry - 16'd1;
         endcase
         model(rx, ry, mq, mr, mdbz, movf, mlat);
         do_div(rx, ry, mq, mr, mdbz, movf, mlat, $sformatf("rnd%0d", i), 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
